// File: rtl/sort_4_32_pkg.sv
// Shared constants and state encoding for the 4-entry sequential sorter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sort_4_32_pkg;

    // Number of words in one sorted set and the width of a slot index.
    localparam int N     = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/sort_4_32_sel.sv
// Combinational extreme selector: picks the lowest (DESC=0) or greatest (DESC=1) live entry.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
//
// Ports:
//   entries_i  N x WIDTH operands, slot 0 in the lowest lane
//   live_i     per-slot mask, 1 = candidate
//   idx_o      slot of the selected entry (0 when nothing is live)
//   val_o      value of the selected entry (0 when nothing is live)
module sel_4_32
    import sort_4_32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit DESC  = 1'b0
) (
    input  logic [N-1:0][WIDTH-1:0] entries_i,
    input  logic [N-1:0]            live_i,
    output logic [IDX_W-1:0]        idx_o,
    output logic [WIDTH-1:0]        val_o
);

    logic [IDX_W-1:0] best_idx;
    logic [WIDTH-1:0] best_val;
    logic             best_found;

    // Scan from slot 0 upward and replace the candidate only on a strict
    // improvement, so an equal value in a higher slot never displaces the
    // lower slot. That keeps the output order stable for both directions.
    always_comb begin
        best_idx   = '0;
        best_val   = '0;
        best_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (live_i[i]) begin
                if (!best_found ||
                    (DESC ? (entries_i[i] > best_val) : (entries_i[i] < best_val))) begin
                    best_found = 1'b1;
                    best_idx   = IDX_W'(i);
                    best_val   = entries_i[i];
                end
            end
        end
    end

    assign idx_o = best_idx;
    assign val_o = best_val;

endmodule

// File: rtl/sort_4_32.sv
// Sequential 4-word sorter: loads four words, then emits them in sorted order with their arrival slot.
// Latency: first sorted word valid the cycle after the 4th input handshake; 8 cycles per set at full rate.
// Backpressure: input stalls for the whole emit phase; outputs hold steady while out_ready_21 is low.
//
// Ports:
//   clk_21, rst_21              clock, synchronous active-high reset
//   in_valid_21/in_ready_21     input handshake, in_data_21 carries the operand
//   out_valid_21/out_ready_21   output handshake, out_data_21 sorted operand,
//                               out_idx_21 original slot, out_last_21 marks the 4th word
//   busy_21                     a set is partially loaded or being emitted
module sort_4_32
    import sort_4_32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit DESC  = 1'b0
) (
    input  logic             clk_21,
    input  logic             rst_21,
    input  logic             in_valid_21,
    output logic             in_ready_21,
    input  logic [WIDTH-1:0] in_data_21,
    output logic             out_valid_21,
    input  logic             out_ready_21,
    output logic [WIDTH-1:0] out_data_21,
    output logic [1:0]       out_idx_21,
    output logic             out_last_21,
    output logic             busy_21
);

    state_e                  state_q;
    logic [IDX_W-1:0]        ld_cnt_q;
    logic [IDX_W-1:0]        out_cnt_q;
    logic [N-1:0]            live_q;
    logic [N-1:0][WIDTH-1:0] reg_q;

    logic [IDX_W-1:0]        sel_idx;
    logic [WIDTH-1:0]        sel_val;
    logic                    emit;
    logic                    in_fire;
    logic                    out_fire;

    sel_4_32 #(
        .WIDTH (WIDTH),
        .DESC  (DESC)
    ) u_sel (
        .entries_i (reg_q),
        .live_i    (live_q),
        .idx_o     (sel_idx),
        .val_o     (sel_val)
    );

    assign emit     = (state_q == ST_EMIT);
    assign in_fire  = in_valid_21 && in_ready_21;
    assign out_fire = emit && out_ready_21;

    // Operand storage carries no control meaning, so it is not reset; the
    // live mask guarantees stale contents are never selected.
    always_ff @(posedge clk_21) begin
        if (in_fire) begin
            reg_q[ld_cnt_q] <= in_data_21;
        end
    end

    always_ff @(posedge clk_21) begin
        if (rst_21) begin
            state_q   <= ST_LOAD;
            ld_cnt_q  <= '0;
            live_q    <= '0;
            out_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_fire) begin
                        ld_cnt_q <= ld_cnt_q + 1'b1;
                        if (ld_cnt_q == IDX_W'(N - 1)) begin
                            live_q    <= '1;
                            out_cnt_q <= '0;
                            state_q   <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_fire) begin
                        live_q[sel_idx] <= 1'b0;
                        out_cnt_q       <= out_cnt_q + 1'b1;
                        if (out_cnt_q == IDX_W'(N - 1)) begin
                            ld_cnt_q <= '0;
                            state_q  <= ST_LOAD;
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    // Output-side signals come only from registered state; reset gating
    // applies to in_ready and busy alone.
    assign out_valid_21 = emit;
    assign out_data_21  = emit ? sel_val : '0;
    assign out_idx_21   = emit ? sel_idx : '0;
    assign out_last_21  = emit && (out_cnt_q == IDX_W'(N - 1));
    assign in_ready_21  = !rst_21 && (state_q == ST_LOAD);
    assign busy_21      = !rst_21 && ((state_q != ST_LOAD) || (ld_cnt_q != '0));

endmodule

// File: tb/tb_sort_4_32.sv
// Self-checking bench for sort_4_32: ascending and descending instances share one stimulus stream.
// A rank-based reference model predicts every output word; directed sets pin the model with literals.
module tb_sort_4_32;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  i;
        logic        l;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    int          rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

    logic        a_ir, a_ov, a_last, a_busy;
    logic [31:0] a_data;
    logic [1:0]  a_idx;
    logic        d_ir, d_ov, d_last, d_busy;
    logic [31:0] d_data;
    logic [1:0]  d_idx;

    sort_4_32 #(.WIDTH(32), .DESC(1'b0)) dut_asc (
        .clk_21(clk), .rst_21(rst),
        .in_valid_21(in_valid), .in_ready_21(a_ir), .in_data_21(in_data),
        .out_valid_21(a_ov), .out_ready_21(out_ready), .out_data_21(a_data),
        .out_idx_21(a_idx), .out_last_21(a_last), .busy_21(a_busy)
    );

    sort_4_32 #(.WIDTH(32), .DESC(1'b1)) dut_desc (
        .clk_21(clk), .rst_21(rst),
        .in_valid_21(in_valid), .in_ready_21(d_ir), .in_data_21(in_data),
        .out_valid_21(d_ov), .out_ready_21(out_ready), .out_data_21(d_data),
        .out_idx_21(d_idx), .out_last_21(d_last), .busy_21(d_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] coll[$];
    ent_t        qa[$];
    ent_t        qd[$];
    ent_t        log_a[$];
    ent_t        log_d[$];

    // Output position of each word = number of words that must precede it.
    function automatic void build(input bit desc, output ent_t e[4]);
        for (int i = 0; i < 4; i++) begin
            int r = 0;
            for (int j = 0; j < 4; j++) begin
                if (j != i) begin
                    if (desc ? (coll[j] > coll[i]) : (coll[j] < coll[i])) r++;
                    else if (coll[j] == coll[i] && j < i) r++;
                end
            end
            e[r] = '{d: coll[i], i: 2'(i), l: (r == 3)};
        end
    endfunction

    task automatic cmp_dut(input string tag, input bit has, input ent_t h,
                           input logic ov, input logic ir, input logic bz,
                           input logic [31:0] od, input logic [1:0] oi, input logic ol);
        chk({tag, "_valid"}, ov, has);
        chk({tag, "_in_ready"}, ir, !rst && !has);
        chk({tag, "_busy"}, bz, !rst && (has || coll.size() != 0));
        chk({tag, "_data"}, od, has ? h.d : 32'h0);
        chk({tag, "_idx"}, oi, has ? h.i : 2'd0);
        chk({tag, "_last"}, ol, has ? h.l : 1'b0);
    endtask

    ent_t ea[4];
    ent_t ed[4];
    ent_t ha, hd;
    bit   has;

    always @(negedge clk) begin
        has = (qa.size() != 0);
        ha  = has ? qa[0] : '0;
        hd  = has ? qd[0] : '0;
        cmp_dut("asc", has, ha, a_ov, a_ir, a_busy, a_data, a_idx, a_last);
        cmp_dut("desc", has, hd, d_ov, d_ir, d_busy, d_data, d_idx, d_last);
        if (rst) begin
            coll.delete();
            qa.delete();
            qd.delete();
        end else begin
            if (in_valid && !has) begin
                coll.push_back(in_data);
                if (coll.size() == 4) begin
                    build(1'b0, ea);
                    build(1'b1, ed);
                    for (int k = 0; k < 4; k++) begin
                        qa.push_back(ea[k]);
                        qd.push_back(ed[k]);
                    end
                    coll.delete();
                end
            end
            if (out_ready && has) begin
                qa.delete(0);
                qd.delete(0);
                log_a.push_back('{d: a_data, i: a_idx, l: a_last});
                log_d.push_back('{d: d_data, i: d_idx, l: d_last});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int  n = 0;
        bit  hs;
        in_valid = 1'b1;
        in_data  = w;
        forever begin
            @(negedge clk);
            hs = a_ir;
            tick();
            if (hs) break;
            n++;
            if (n > 200) begin
                timeout_fail("send");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send4(input logic [31:0] w0, w1, w2, w3);
        send(w0);
        send(w1);
        send(w2);
        send(w3);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((qa.size() != 0 || coll.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) timeout_fail("drain");
    endtask

    task automatic chk_log(input string nm, input bit desc, input int k,
                           input logic [31:0] d, input logic [1:0] i, input logic l);
        ent_t e;
        if ((desc ? log_d.size() : log_a.size()) <= k) begin
            timeout_fail({nm, "_missing"});
        end else begin
            e = desc ? log_d[k] : log_a[k];
            chk({nm, "_data"}, e.d, d);
            chk({nm, "_idx"}, e.i, i);
            chk({nm, "_last"}, e.l, l);
        end
    endtask

    task automatic clear_logs();
        log_a.delete();
        log_d.delete();
    endtask

    logic [31:0] stall_d;
    logic [1:0]  stall_i;
    logic [31:0] rv;
    int          n;

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_out_valid", a_ov, 1'b0);
        chk("rst_in_ready", a_ir, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", a_ir, 1'b1);
        tick();

        // ascending basic + latency
        rdy_mode = 0;
        clear_logs();
        send(32'd7);
        send(32'd3);
        send(32'd9);
        chk("pre_valid", a_ov, 1'b0);
        send(32'd1);
        chk("lat_valid", a_ov, 1'b1);
        wait_drain();
        chk_log("basic0", 0, 0, 32'd1, 2'd3, 1'b0);
        chk_log("basic1", 0, 1, 32'd3, 2'd1, 1'b0);
        chk_log("basic2", 0, 2, 32'd7, 2'd0, 1'b0);
        chk_log("basic3", 0, 3, 32'd9, 2'd2, 1'b1);
        chk_log("basic_d0", 1, 0, 32'd9, 2'd2, 1'b0);
        chk_log("basic_d3", 1, 3, 32'd1, 2'd3, 1'b1);
        chk("b2b_in_ready", a_ir, 1'b1);

        // ties / stability
        clear_logs();
        send4(32'd5, 32'd5, 32'd2, 32'd5);
        wait_drain();
        chk_log("tie_a0", 0, 0, 32'd2, 2'd2, 1'b0);
        chk_log("tie_a1", 0, 1, 32'd5, 2'd0, 1'b0);
        chk_log("tie_a2", 0, 2, 32'd5, 2'd1, 1'b0);
        chk_log("tie_a3", 0, 3, 32'd5, 2'd3, 1'b1);
        chk_log("tie_d0", 1, 0, 32'd5, 2'd0, 1'b0);
        chk_log("tie_d1", 1, 1, 32'd5, 2'd1, 1'b0);
        chk_log("tie_d2", 1, 2, 32'd5, 2'd3, 1'b0);
        chk_log("tie_d3", 1, 3, 32'd2, 2'd2, 1'b1);

        // extremes, unsigned compare
        clear_logs();
        send4(32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1);
        wait_drain();
        chk_log("ext0", 0, 0, 32'h0, 2'd1, 1'b0);
        chk_log("ext1", 0, 1, 32'h1, 2'd3, 1'b0);
        chk_log("ext2", 0, 2, 32'h8000_0000, 2'd2, 1'b0);
        chk_log("ext3", 0, 3, 32'hFFFF_FFFF, 2'd0, 1'b1);

        // backpressure mid-emit with ignored input pulses
        clear_logs();
        rdy_mode = 1;
        send4(32'd10, 32'd40, 32'd20, 32'd30);
        tick();
        rdy_mode = 0;
        tick();
        rdy_mode = 1;
        tick();
        stall_d = a_data;
        stall_i = a_idx;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_data  = 32'hDEAD_0000 + 32'(c);
            tick();
            chk("bp_in_ready", a_ir, 1'b0);
        end
        in_valid = 1'b0;
        chk("bp_hold_data", a_data, stall_d);
        chk("bp_hold_idx", a_idx, stall_i);
        chk("bp_hold_data_lit", a_data, 32'd20);
        rdy_mode = 0;
        wait_drain();
        chk("bp_count", log_a.size(), 4);
        chk_log("bp0", 0, 0, 32'd10, 2'd0, 1'b0);
        chk_log("bp1", 0, 1, 32'd20, 2'd2, 1'b0);
        chk_log("bp2", 0, 2, 32'd30, 2'd3, 1'b0);
        chk_log("bp3", 0, 3, 32'd40, 2'd1, 1'b1);

        // reset after two loads
        send(32'd99);
        send(32'd1);
        rst = 1'b1;
        tick();
        tick();
        chk("rstl_valid", a_ov, 1'b0);
        chk("rstl_in_ready", a_ir, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstl_rel_ready", a_ir, 1'b1);
        tick();

        // reset after two emits
        clear_logs();
        send4(32'd50, 32'd60, 32'd70, 32'd80);
        n = 0;
        while (log_a.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout_fail("rste_wait");
        rst = 1'b1;
        tick();
        tick();
        chk("rste_valid", a_ov, 1'b0);
        chk("rste_in_ready", a_ir, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rste_rel_ready", a_ir, 1'b1);
        chk("rste_count", log_a.size(), 2);
        tick();

        clear_logs();
        send4(32'd4, 32'd8, 32'd6, 32'd2);
        wait_drain();
        chk_log("fresh0", 0, 0, 32'd2, 2'd3, 1'b0);
        chk_log("fresh1", 0, 1, 32'd4, 2'd0, 1'b0);
        chk_log("fresh2", 0, 2, 32'd6, 2'd2, 1'b0);
        chk_log("fresh3", 0, 3, 32'd8, 2'd1, 1'b1);

        // random back-to-back sets with gaps
        clear_logs();
        rdy_mode = 2;
        for (int s = 0; s < 100; s++) begin
            for (int w = 0; w < 4; w++) begin
                repeat ($urandom_range(0, 2)) tick();
                rv = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 5));
                send(rv);
            end
        end
        wait_drain();
        chk("rand_count", log_a.size(), 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
